// File: rtl/router_out_arbiter_if.sv
// Handshake bundle between the per-port input buffers, the output arbiter and
// the output link driver. The slave modport is the arbiter's view of the bundle;
// the master modport is the view of the logic that surrounds it.
interface router_out_arbiter_if #(
  parameter int unsigned NREQ = 5,
  parameter int unsigned DW   = 8
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_tail;

  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic               out_tail;

  logic [NREQ-1:0]    grant;
  logic               busy;

  modport master (
    output req_valid, req_data, req_tail, out_ready,
    input  req_ready, out_valid, out_data, out_tail, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_tail, out_ready,
    output req_ready, out_valid, out_data, out_tail, grant, busy
  );

endinterface

// File: rtl/router_out_arbiter.sv
// Router output-port arbiter. Shares one output channel among NREQ input
// buffers: a round-robin winner is granted, its flits are moved through a
// one-entry output register, and the grant is released for re-arbitration.
//
// Build option ARB_PKT_LOCK_EN:
//   defined   - the grant is held for a whole packet and released only when
//               the tail flit is accepted.
//   undefined - per-flit arbitration: every accepted flit releases the grant.
//               req_tail is still forwarded on out_tail.
module router_out_arbiter #(
  parameter int unsigned NREQ = 5,
  parameter int unsigned DW   = 8
) (
  input logic                clk,
  input logic                reset,
  router_out_arbiter_if.slave bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StLock
  } state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               out_tail_q, out_tail_d;

  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      owner;
  logic [DW-1:0]      own_data;
  logic               own_tail;
  logic               out_free;
  logic [NREQ-1:0]    req_ready;
  logic               xfer;
  logic               release_grant;

  // Round-robin search starting just after the last served port
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = PW'((32'(ptr_q) + off) % NREQ);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Encode the one-hot owner and select its flit
  always_comb begin
    owner    = '0;
    own_data = '0;
    own_tail = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner = PW'(i);
      end
      own_data = own_data | (bus.req_data[i*DW +: DW] & {DW{grant_q[i]}});
      own_tail = own_tail | (bus.req_tail[i] & grant_q[i]);
    end
  end

  // The output register can take a flit when empty or draining this cycle
  assign out_free = !out_valid_q || bus.out_ready;

  // Only the owner sees ready, and nobody does while reset is applied
  always_comb begin
    req_ready = '0;
    if (state_q == StLock && reset) begin
      req_ready = grant_q & {NREQ{out_free}};
    end
  end

  assign xfer = |(bus.req_valid & req_ready);

`ifdef ARB_PKT_LOCK_EN
  assign release_grant = own_tail;
`else
  assign release_grant = 1'b1;
`endif

  // Next-state logic for the FSM, grant, pointer and output register
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tail_d  = out_tail_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          state_d          = StLock;
        end
      end
      StLock: begin
        if (xfer) begin
          // A load overrides a same-cycle drain, giving one flit per cycle
          out_valid_d = 1'b1;
          out_data_d  = own_data;
          out_tail_d  = own_tail;
          if (release_grant) begin
            grant_d = '0;
            ptr_d   = owner;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset; a reset drops any held flit
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      ptr_q       <= PW'(NREQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tail_q  <= out_tail_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q == StLock);

  // Grant is one-hot or zero and busy follows it
  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant_q) && (bus.busy == |grant_q));

  // Ready is only ever offered to the owner
  a_ready_owner: assert property (@(posedge clk) disable iff (!reset)
    (req_ready & ~grant_q) == '0);

  // A stalled flit is held unchanged
  a_stall_hold: assert property (@(posedge clk) disable iff (!reset)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q) &&
                                         $stable(out_tail_q)));

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed, table-driven bench for router_out_arbiter. Each record gives the
// inputs for one cycle and the outputs expected while those inputs are applied.
module tb_router_out_arbiter;

  localparam int unsigned NREQ = 5;
  localparam int unsigned DW   = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  router_out_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  router_out_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         sec;
    logic       rst;
    logic [4:0] vld;
    logic [4:0] tail;
    logic [39:0] data;
    logic       ordy;
    logic [4:0] e_rdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ot;
    logic [4:0] e_gnt;
  } vec_t;

  vec_t vecs[$];
  int   sec      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [39:0] pd(input int p, input logic [7:0] b);
    logic [39:0] r;
    r = '0;
    r[p*8 +: 8] = b;
    return r;
  endfunction

  function automatic void add(input logic rst, input logic [4:0] vld, input logic [4:0] tail,
                              input logic [39:0] data, input logic ordy,
                              input logic [4:0] e_rdy, input logic e_ov, input logic [7:0] e_od,
                              input logic e_ot, input logic [4:0] e_gnt);
    vec_t v;
    v.sec = sec; v.rst = rst; v.vld = vld; v.tail = tail; v.data = data; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_ot = e_ot; v.e_gnt = e_gnt;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [39:0] d_a, d_b, d_c;
    logic [4:0]  g_mid;
    int          wait_cnt;

    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_tail  = '0;
    bus.out_ready = 1'b1;

`ifdef ARB_PKT_LOCK_EN
    g_mid = 5'b01000;
`else
    g_mid = 5'b00000;
`endif

    // 1: idle after reset
    sec = 1;
    for (int i = 0; i < 10; i++) add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'h00, 1'b0, '0);

    // 2: port 2 sends 0x11, 0x22, 0x33 (tail)
    sec = 2;
`ifdef ARB_PKT_LOCK_EN
    add(1'b1, 5'b00100, '0, pd(2, 8'h11), 1'b1, '0, 1'b0, 8'h00, 1'b0, '0);
    add(1'b1, 5'b00100, '0, pd(2, 8'h11), 1'b1, 5'b00100, 1'b0, 8'h00, 1'b0, 5'b00100);
    add(1'b1, 5'b00100, '0, pd(2, 8'h22), 1'b1, 5'b00100, 1'b1, 8'h11, 1'b0, 5'b00100);
    add(1'b1, 5'b00100, 5'b00100, pd(2, 8'h33), 1'b1, 5'b00100, 1'b1, 8'h22, 1'b0, 5'b00100);
`else
    add(1'b1, 5'b00100, '0, pd(2, 8'h11), 1'b1, '0, 1'b0, 8'h00, 1'b0, '0);
    add(1'b1, 5'b00100, '0, pd(2, 8'h11), 1'b1, 5'b00100, 1'b0, 8'h00, 1'b0, 5'b00100);
    add(1'b1, 5'b00100, '0, pd(2, 8'h22), 1'b1, '0, 1'b1, 8'h11, 1'b0, '0);
    add(1'b1, 5'b00100, '0, pd(2, 8'h22), 1'b1, 5'b00100, 1'b0, 8'h11, 1'b0, 5'b00100);
    add(1'b1, 5'b00100, 5'b00100, pd(2, 8'h33), 1'b1, '0, 1'b1, 8'h22, 1'b0, '0);
    add(1'b1, 5'b00100, 5'b00100, pd(2, 8'h33), 1'b1, 5'b00100, 1'b0, 8'h22, 1'b0, 5'b00100);
`endif
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b1, 8'h33, 1'b1, '0);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'h33, 1'b1, '0);

    // 3: reset, then ports 0, 1, 4 with single-flit packets, twice (ptr wraps 4 -> 0)
    sec = 3;
    add(1'b0, '0, '0, '0, 1'b1, '0, 1'b0, 8'h33, 1'b1, '0);
    d_a = pd(0, 8'hA0) | pd(1, 8'hA1) | pd(4, 8'hA4);
    d_b = pd(0, 8'hB0) | pd(1, 8'hB1) | pd(4, 8'hB4);
    add(1'b1, 5'b10011, 5'b10011, d_a, 1'b1, '0, 1'b0, 8'h00, 1'b0, '0);
    add(1'b1, 5'b10011, 5'b10011, d_a, 1'b1, 5'b00001, 1'b0, 8'h00, 1'b0, 5'b00001);
    add(1'b1, 5'b10010, 5'b10011, d_a, 1'b1, '0, 1'b1, 8'hA0, 1'b1, '0);
    add(1'b1, 5'b10010, 5'b10011, d_a, 1'b1, 5'b00010, 1'b0, 8'hA0, 1'b1, 5'b00010);
    add(1'b1, 5'b10000, 5'b10011, d_a, 1'b1, '0, 1'b1, 8'hA1, 1'b1, '0);
    add(1'b1, 5'b10000, 5'b10011, d_a, 1'b1, 5'b10000, 1'b0, 8'hA1, 1'b1, 5'b10000);
    add(1'b1, 5'b10011, 5'b10011, d_b, 1'b1, '0, 1'b1, 8'hA4, 1'b1, '0);
    add(1'b1, 5'b10011, 5'b10011, d_b, 1'b1, 5'b00001, 1'b0, 8'hA4, 1'b1, 5'b00001);
    add(1'b1, 5'b10010, 5'b10011, d_b, 1'b1, '0, 1'b1, 8'hB0, 1'b1, '0);
    add(1'b1, 5'b10010, 5'b10011, d_b, 1'b1, 5'b00010, 1'b0, 8'hB0, 1'b1, 5'b00010);
    add(1'b1, 5'b10000, 5'b10011, d_b, 1'b1, '0, 1'b1, 8'hB1, 1'b1, '0);
    add(1'b1, 5'b10000, 5'b10011, d_b, 1'b1, 5'b10000, 1'b0, 8'hB1, 1'b1, 5'b10000);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b1, 8'hB4, 1'b1, '0);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'hB4, 1'b1, '0);

    // 4: port 3 with downstream stalled for 4 cycles
    sec = 4;
    add(1'b1, 5'b01000, '0, pd(3, 8'h31), 1'b1, '0, 1'b0, 8'hB4, 1'b1, '0);
    add(1'b1, 5'b01000, '0, pd(3, 8'h31), 1'b1, 5'b01000, 1'b0, 8'hB4, 1'b1, 5'b01000);
    add(1'b1, 5'b01000, 5'b01000, pd(3, 8'h32), 1'b0, '0, 1'b1, 8'h31, 1'b0, g_mid);
    for (int i = 0; i < 3; i++)
      add(1'b1, 5'b01000, 5'b01000, pd(3, 8'h32), 1'b0, '0, 1'b1, 8'h31, 1'b0, 5'b01000);
    add(1'b1, 5'b01000, 5'b01000, pd(3, 8'h32), 1'b1, 5'b01000, 1'b1, 8'h31, 1'b0, 5'b01000);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b1, 8'h32, 1'b1, '0);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'h32, 1'b1, '0);

    // 5: owner port 1 drops valid for 3 cycles while port 0 waits
    sec = 5;
    d_a = pd(0, 8'h50) | pd(1, 8'h51);
    add(1'b1, 5'b00010, 5'b00010, d_a, 1'b1, '0, 1'b0, 8'h32, 1'b1, '0);
    for (int i = 0; i < 3; i++)
      add(1'b1, 5'b00001, 5'b00011, d_a, 1'b1, 5'b00010, 1'b0, 8'h32, 1'b1, 5'b00010);
    add(1'b1, 5'b00011, 5'b00011, d_a, 1'b1, 5'b00010, 1'b0, 8'h32, 1'b1, 5'b00010);
    add(1'b1, 5'b00001, 5'b00011, d_a, 1'b1, '0, 1'b1, 8'h51, 1'b1, '0);
    add(1'b1, 5'b00001, 5'b00011, d_a, 1'b1, 5'b00001, 1'b0, 8'h51, 1'b1, 5'b00001);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b1, 8'h50, 1'b1, '0);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'h50, 1'b1, '0);

    // 6: reset mid-packet, then port 0 wins over port 4
    sec = 6;
`ifdef ARB_PKT_LOCK_EN
    g_mid = 5'b00100;
`else
    g_mid = 5'b00000;
`endif
    add(1'b1, 5'b00100, '0, pd(2, 8'h61), 1'b1, '0, 1'b0, 8'h50, 1'b1, '0);
    add(1'b1, 5'b00100, '0, pd(2, 8'h61), 1'b1, 5'b00100, 1'b0, 8'h50, 1'b1, 5'b00100);
    add(1'b1, 5'b00100, '0, pd(2, 8'h62), 1'b0, '0, 1'b1, 8'h61, 1'b0, g_mid);
    d_a = pd(0, 8'h70) | pd(2, 8'h62) | pd(4, 8'h74);
    add(1'b0, 5'b10101, 5'b10001, d_a, 1'b1, '0, 1'b1, 8'h61, 1'b0, 5'b00100);
    d_a = pd(0, 8'h70) | pd(4, 8'h74);
    add(1'b1, 5'b10001, 5'b10001, d_a, 1'b1, '0, 1'b0, 8'h00, 1'b0, '0);
    add(1'b1, 5'b10001, 5'b10001, d_a, 1'b1, 5'b00001, 1'b0, 8'h00, 1'b0, 5'b00001);
    add(1'b1, 5'b10000, 5'b10001, d_a, 1'b1, '0, 1'b1, 8'h70, 1'b1, '0);
    add(1'b1, 5'b10000, 5'b10001, d_a, 1'b1, 5'b10000, 1'b0, 8'h70, 1'b1, 5'b10000);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b1, 8'h74, 1'b1, '0);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'h74, 1'b1, '0);

    // 7: ports 0 and 2 each send a 2-flit packet at the same time
    sec = 7;
    d_a = pd(0, 8'h80) | pd(2, 8'h82);
    d_b = pd(0, 8'h81) | pd(2, 8'h82);
    d_c = pd(0, 8'h81) | pd(2, 8'h83);
    add(1'b1, 5'b00101, '0, d_a, 1'b1, '0, 1'b0, 8'h74, 1'b1, '0);
    add(1'b1, 5'b00101, '0, d_a, 1'b1, 5'b00001, 1'b0, 8'h74, 1'b1, 5'b00001);
`ifdef ARB_PKT_LOCK_EN
    add(1'b1, 5'b00101, 5'b00001, d_b, 1'b1, 5'b00001, 1'b1, 8'h80, 1'b0, 5'b00001);
    add(1'b1, 5'b00100, '0, pd(2, 8'h82), 1'b1, '0, 1'b1, 8'h81, 1'b1, '0);
    add(1'b1, 5'b00100, '0, pd(2, 8'h82), 1'b1, 5'b00100, 1'b0, 8'h81, 1'b1, 5'b00100);
    add(1'b1, 5'b00100, 5'b00100, pd(2, 8'h83), 1'b1, 5'b00100, 1'b1, 8'h82, 1'b0, 5'b00100);
`else
    add(1'b1, 5'b00101, 5'b00001, d_b, 1'b1, '0, 1'b1, 8'h80, 1'b0, '0);
    add(1'b1, 5'b00101, 5'b00001, d_b, 1'b1, 5'b00100, 1'b0, 8'h80, 1'b0, 5'b00100);
    add(1'b1, 5'b00101, 5'b00101, d_c, 1'b1, '0, 1'b1, 8'h82, 1'b0, '0);
    add(1'b1, 5'b00101, 5'b00101, d_c, 1'b1, 5'b00001, 1'b0, 8'h82, 1'b0, 5'b00001);
    add(1'b1, 5'b00100, 5'b00101, d_c, 1'b1, '0, 1'b1, 8'h81, 1'b1, '0);
    add(1'b1, 5'b00100, 5'b00101, d_c, 1'b1, 5'b00100, 1'b0, 8'h81, 1'b1, 5'b00100);
`endif
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b1, 8'h83, 1'b1, '0);
    add(1'b1, '0, '0, '0, 1'b1, '0, 1'b0, 8'h83, 1'b1, '0);

    // Initial reset for two edges, then apply the table
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.req_ready === '0 && bus.out_valid === 1'b0 && bus.out_data === '0 &&
        bus.out_tail === 1'b0 && bus.grant === '0 && bus.busy === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL reset state: rdy=%b ov=%b od=%h ot=%b gnt=%b busy=%b",
               bus.req_ready, bus.out_valid, bus.out_data, bus.out_tail, bus.grant, bus.busy);
    end

    foreach (vecs[k]) begin
      logic [20:0] got, want;
      @(negedge clk);
      reset         = vecs[k].rst;
      bus.req_valid = vecs[k].vld;
      bus.req_tail  = vecs[k].tail;
      bus.req_data  = vecs[k].data;
      bus.out_ready = vecs[k].ordy;
      #1;
      got  = {bus.req_ready, bus.out_valid, bus.out_data, bus.out_tail, bus.grant, bus.busy};
      want = {vecs[k].e_rdy, vecs[k].e_ov, vecs[k].e_od, vecs[k].e_ot, vecs[k].e_gnt,
              |vecs[k].e_gnt};
      n_checks++;
      if (got === want) begin
        n_pass++;
      end else begin
        $display("FAIL vec %0d sec %0d: got rdy=%b ov=%b od=%h ot=%b gnt=%b busy=%b, want rdy=%b ov=%b od=%h ot=%b gnt=%b busy=%b",
                 k, vecs[k].sec, bus.req_ready, bus.out_valid, bus.out_data, bus.out_tail,
                 bus.grant, bus.busy, vecs[k].e_rdy, vecs[k].e_ov, vecs[k].e_od, vecs[k].e_ot,
                 vecs[k].e_gnt, |vecs[k].e_gnt);
      end
    end

    // Bounded wait for the arbiter to settle back to idle
    wait_cnt = 0;
    while ((bus.busy !== 1'b0 || bus.out_valid !== 1'b0) && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    n_checks++;
    if (bus.busy === 1'b0 && bus.out_valid === 1'b0 && bus.grant === '0) begin
      n_pass++;
    end else begin
      $display("FAIL wait expired after %0d cycles: busy=%b ov=%b gnt=%b",
               wait_cnt, bus.busy, bus.out_valid, bus.grant);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Clocked output-port arbiter for the router. It shares one output channel among NREQ input buffers (N/E/S/W/local), one packet at a time.
- Each input buffer presents flits on a valid/ready channel. The arbiter grants one buffer round-robin, holds the grant until the tail flit passes, and forwards flits through a one-entry output register.
- The block sits between the per-port input buffers and the output link driver.

Parameters:
- NREQ, 5, number of requesting input ports
- DW, 8, flit data width in bits

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-low reset; sampled on rising clk; 0 = reset
- req_valid  input  NREQ  per-port flit valid
- req_ready  output  NREQ  per-port flit accept; at most one bit set
- req_data  input  NREQ*DW  per-port flit data, port i at bits [i*DW +: DW]
- req_tail  input  NREQ  per-port last-flit-of-packet flag
- out_valid  output  1  output register holds a flit
- out_ready  input  1  downstream accepts flit
- out_data  output  DW  output flit data
- out_tail  output  1  output flit is tail
- grant  output  NREQ  registered one-hot current owner; all-zero when idle
- busy  output  1  1 while state is LOCK

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE, grant=0, busy=0, out_valid=0, out_data=0, out_tail=0.
  - Round-robin pointer ptr=NREQ-1, so port 0 has first priority.
  - req_ready=0 throughout reset.
  - Reset mid-packet aborts the packet. The held out_valid flit is discarded with no handshake.
- States: IDLE, LOCK.
- IDLE:
  - req_ready=0.
  - If any req_valid: winner = first i with req_valid[i], searching ptr+1, ptr+2, ... mod NREQ.
  - Next edge: grant<=onehot(winner), state<=LOCK.
  - If no req_valid: stay IDLE.
- LOCK, with owner g:
  - req_ready[g] = !out_valid || out_ready. All other req_ready bits = 0.
  - Transfer occurs when req_valid[g] && req_ready[g]. On the edge: out_data<=req_data[g], out_tail<=req_tail[g], out_valid<=1.
  - If the transferred flit has req_tail[g]==1: grant<=0, ptr<=g, state<=IDLE.
- Output register:
  - When out_valid && out_ready with no new load, out_valid<=0.
  - Load and drain in the same cycle gives out_valid=1 holding the new flit. Throughput is 1 flit/cycle.
  - out_data and out_tail hold stable while out_valid && !out_ready.
- Latency:
  - req_valid rising before edge t gives grant at t.
  - The first flit is accepted at edge t+1 and appears on out_valid after t+1.
  - One idle (bubble) cycle between packets for re-arbitration.
- Boundary conditions:
  - Owner drops req_valid mid-packet: grant held indefinitely, no timeout, no transfer.
  - Non-owner req_valid changes during LOCK are ignored.
  - Single-flit packet (tail on first flit): LOCK lasts exactly one accept.
  - Simultaneous tail accept and new requests: the new winner is computed in the following IDLE cycle using the updated ptr.
  - Downstream stalled (out_ready=0, out_valid=1): req_ready[g]=0 and no data loss.
  - ptr wraps NREQ-1 -> 0.
  - grant is always one-hot or zero. busy equals |grant.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined: packet locking as above. The grant is released only on an accepted tail flit.
- Undefined: per-flit arbitration.
  - Every accepted flit returns the FSM to IDLE with ptr<=g, whatever req_tail is.
  - req_tail is still forwarded to out_tail.
  - Flits of different ports interleave round-robin, each separated by one bubble cycle.

Test Plan:
- Reset then all idle -> out_valid=0, grant=0, req_ready=0 for 10 cycles; busy=0.
- Port 2 sends a 3-flit packet 0x11, 0x22, 0x33 (tail on 0x33), out_ready=1 -> grant=5'b00100 after 1 cycle; out_data sequence 0x11, 0x22, 0x33 on consecutive cycles; out_tail=1 only with 0x33; grant=0 afterwards.
- Ports 0, 1, 4 request at the same edge after reset, each with a 1-flit packet -> service order 0, 1, 4, one bubble between packets. Repeat all three requesting -> order 0, 1, 4 again (ptr=4 wraps to 0).
- Port 3 mid-packet with out_ready=0 for 4 cycles -> req_ready[3]=0, out_data frozen; then out_ready=1 -> remaining flits delivered, none dropped or duplicated.
- Port 1 in LOCK drops req_valid for 3 cycles while port 0 requests -> grant stays 5'b00010; port 0 served only after port 1's tail.
- reset=0 asserted mid-packet -> next cycle out_valid=0, grant=0; port 0 wins first afterwards.
- ARB_PKT_LOCK_EN undefined: ports 0 and 2 each send 2-flit packets simultaneously -> out order P0f0, P2f0, P0f1, P2f1.
